sqnc_detect_ctrl: RTL and testbench
===================================

Name: sqnc_detect_ctrl

Overview:
- Controller that sequences a serial pattern detector from a parallel word source.
- Accepts DATA_W-bit words over a valid/ready handshake and serialises them MSB-first into a PAT_W-bit pattern-match window.
- Reports per-bit match pulses and a per-word match count with a done strobe.
- Sits between a word-oriented producer and the serial detection datapath; owns the pattern configuration.

Parameters:
- DATA_W, 16: word width, bits serialised per word.
- PAT_W, 5: pattern length in bits.
- PAT_DEF, 5'b10111: pattern loaded at reset.
- CNT_W, 5: match-count width; must satisfy 2^CNT_W-1 >= DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  pattern/mode write strobe; honoured only in IDLE.
- cfg_pat  in  PAT_W  new pattern.
- cfg_overlap  in  1  1 = overlapping matches counted; 0 = non-overlapping.
- in_valid  in  1  word available.
- in_data  in  DATA_W  word.
- in_ready  out  1  controller can accept a word.
- bit_out  out  1  serial bit currently presented.
- bit_vld  out  1  bit_out is valid this cycle.
- match  out  1  pattern completes on the current bit (Mealy).
- done  out  1  one-cycle strobe after the last bit of a word.
- match_cnt  out  CNT_W  matches in the last completed word.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset state (asynchronous, immediate):
  - State IDLE; shift register, bit index, history, fill counter and match_cnt are 0.
  - Pattern register = PAT_DEF; overlap mode = 1.
  - Outputs: bit_vld=0, match=0, done=0, busy=0, in_ready=1 (in_ready is decoded from state, so it is also 1 while rst is held).
- State machine, one-hot: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on in_valid & in_ready. The word is latched, bit index is cleared and the word count is cleared.
  - SHIFT lasts exactly DATA_W cycles. Each cycle presents bit_out = shreg[DATA_W-1] with bit_vld=1, then shifts left and increments the index.
  - SHIFT -> DONE after index DATA_W-1.
  - DONE lasts one cycle: done=1, match_cnt updated with that word's count. DONE -> IDLE.
- Timing: accept at edge T; bits at cycles T+1..T+DATA_W; done at T+DATA_W+1; in_ready high again at T+DATA_W+2. Throughput is one word per DATA_W+2 cycles.
- in_ready=1 only in IDLE. in_data is ignored outside the accept cycle.
- Match window:
  - History register holds the last PAT_W-1 bits. Fill counter saturates at PAT_W-1.
  - match = bit_vld & (fill == PAT_W-1) & ({hist, bit_out} == pattern). match is combinational in the same cycle as the bit.
  - Each valid bit shifts into the history.
  - Overlap mode 1: fill is unaffected by a match.
  - Overlap mode 0: fill resets to 0 on a match, so the next match needs PAT_W fresh bits.
- History and fill persist across words, so matches may straddle a word boundary. Only rst or an accepted cfg_we clears them.
- Word count increments on each match and saturates at 2^CNT_W-1. match_cnt holds its value until the next DONE.
- cfg_we:
  - In IDLE: loads pattern and overlap mode, clears history and fill.
  - In SHIFT or DONE: ignored with no side effects.
  - cfg_we and in_valid in the same IDLE cycle: both take effect, and the word uses the new configuration.
- Reset mid-word: the word is abandoned with no done, and the configuration returns to its defaults.

Decomposition:
- Package sqnc_pkg:
  - One-hot state localparams for IDLE, SHIFT and DONE.
  - Default pattern constant and default overlap mode.
- Sub-module pattern_window:
  - Contents: history register, fill counter, comparator, match output.
  - Inputs: clk, rst, clear, bit, bit_vld, pattern, overlap.
  - The controller instantiates one pattern_window.

Test Plan:
- Reset, then word 0xB800 with the default pattern and overlap mode 1 → match on the 5th bit (T+5), done at T+17, match_cnt=1, in_ready back at T+18.
- Word 0xBB80 with overlap mode 1 → matches on bits 5 and 9, match_cnt=2. Repeat after rst with cfg_overlap=0 → match_cnt=1.
- Cross-word straddle: word 0x0005 then word 0xC000 → first done shows match_cnt=0; match on the 2nd bit of the second word; second done shows match_cnt=1.
- In IDLE, cfg_we with cfg_pat=5'b11111:
  - Word 0xFFFF with overlap mode 1 → match_cnt=12.
  - Same word with overlap mode 0 → match_cnt=3.
  - cfg_we pulsed during SHIFT → pattern unchanged and the count is unaffected.
- Hold in_valid high with changing in_data during SHIFT → no accept until IDLE; the serialised bits equal the originally latched word.
- Assert rst at the 7th bit of a word → bit_vld, match, busy and done are 0 immediately; in_ready=1; after release, 0xB800 yields match_cnt=1, proving the pattern is back at PAT_DEF and the history is cleared.

Source files
------------

// File: rtl/sqnc_pkg.sv
// rtl/sqnc_pkg.sv - shared state encoding and configuration defaults for sqnc_detect_ctrl
package sqnc_pkg;

    localparam logic [2:0] ST_IDLE_OH  = 3'b001;
    localparam logic [2:0] ST_SHIFT_OH = 3'b010;
    localparam logic [2:0] ST_DONE_OH  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE_OH,
        S_SHIFT = ST_SHIFT_OH,
        S_DONE  = ST_DONE_OH
    } state_t;

    localparam int           PAT_W_DEF   = 5;
    localparam logic [4:0]   PAT_DEF_C   = 5'b10111;
    localparam logic         OVERLAP_DEF = 1'b1;

endpackage

// File: rtl/pattern_window.sv
// rtl/pattern_window.sv - serial pattern-match window: bit history, fill counter, comparator
module pattern_window #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_bit,
    input  logic             i_bit_vld,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_overlap,
    output logic             o_match
);

    localparam int                FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_window;

    assign w_window = {r_hist, i_bit};
    assign o_match  = i_bit_vld && (r_fill == FULL) && (w_window == i_pattern);

    // Non-overlapping mode restarts the fill so the next hit needs PAT_W fresh bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_bit_vld) begin
            r_hist <= w_window[PAT_W-2:0];
            if (o_match && !i_overlap) begin
                r_fill <= '0;
            end else if (r_fill != FULL) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sqnc_detect_ctrl.sv
// rtl/sqnc_detect_ctrl.sv - word-to-serial sequencer driving a pattern detector, with per-word match count
module sqnc_detect_ctrl
    import sqnc_pkg::*;
#(
    parameter int               DATA_W  = 16,
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PAT_DEF = PAT_DEF_C,
    parameter int               CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_vld,
    output logic              match,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy
);

    localparam int               IDX_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_shreg;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt, r_match_cnt, w_cnt_nxt;
    logic [PAT_W-1:0]    r_pat;
    logic                r_overlap;
    logic                w_accept, w_cfg_load, w_last;

    assign w_accept   = in_valid && in_ready;
    assign w_cfg_load = cfg_we && (r_state == S_IDLE);
    assign w_last     = (r_state == S_SHIFT) && (r_idx == IDX_W'(DATA_W - 1));
    assign w_cnt_nxt  = (match && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;
    assign bit_out    = r_shreg[DATA_W-1];
    assign match_cnt  = r_match_cnt;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        bit_vld     = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                bit_vld = 1'b1;
                busy    = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // match_cnt is published on the last bit so it is already valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_match_cnt <= '0;
            r_pat       <= PAT_DEF;
            r_overlap   <= OVERLAP_DEF;
        end else begin
            r_state <= w_state_nxt;
            if (w_cfg_load) begin
                r_pat     <= cfg_pat;
                r_overlap <= cfg_overlap;
            end
            if (w_accept) begin
                r_shreg <= in_data;
                r_idx   <= '0;
                r_cnt   <= '0;
            end else if (bit_vld) begin
                r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                r_idx   <= r_idx + IDX_W'(1);
                r_cnt   <= w_cnt_nxt;
                if (w_last) r_match_cnt <= w_cnt_nxt;
            end
        end
    end

    pattern_window #(.PAT_W(PAT_W)) u_window (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_cfg_load),
        .i_bit     (bit_out),
        .i_bit_vld (bit_vld),
        .i_pattern (r_pat),
        .i_overlap (r_overlap),
        .o_match   (match)
    );

endmodule

// File: tb/tb_sqnc_detect_ctrl.sv
// tb/tb_sqnc_detect_ctrl.sv - self-checking bench for sqnc_detect_ctrl (vector table, corner sequences, random vs model)
module tb_sqnc_detect_ctrl;

    localparam int DATA_W = 16;
    localparam int PAT_W  = 5;
    localparam int CNT_W  = 5;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, cfg_we, cfg_overlap, in_valid;
    logic [PAT_W-1:0]  cfg_pat;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, bit_out, bit_vld, match, done, busy;
    logic [CNT_W-1:0]  match_cnt;

    always #5 clk = ~clk;

    sqnc_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PAT_DEF(5'b10111), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_overlap(cfg_overlap),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .bit_out(bit_out),
        .bit_vld(bit_vld), .match(match), .done(done), .match_cnt(match_cnt), .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: bit stream since the last clear, matched against the pattern by position.
    int                m_phase;
    logic [DATA_W-1:0] m_word;
    logic [PAT_W-1:0]  m_pat;
    bit                m_ovl;
    bit                m_win[$];
    int                m_pos, m_last_end, m_cnt, m_match_cnt;
    bit                e_match;
    bit                s_done, s_match, s_vld, s_bit;
    int                s_cnt;

    function automatic void model_clear();
        m_win.delete();
        m_pos = 0;
        m_last_end = -1000;
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_pat = 5'b10111; m_ovl = 1'b1;
        m_cnt = 0; m_match_cnt = 0; m_word = '0;
        model_clear();
    endfunction

    function automatic bit model_bit();
        return m_word[DATA_W - m_phase];
    endfunction

    function automatic bit model_match();
        if (m_phase < 1 || m_phase > DATA_W) return 1'b0;
        if (m_pos < PAT_W - 1) return 1'b0;
        for (int i = 0; i < PAT_W - 1; i++)
            if (m_win[m_win.size() - (PAT_W - 1) + i] != m_pat[PAT_W-1-i]) return 1'b0;
        if (model_bit() != m_pat[0]) return 1'b0;
        return m_ovl || (m_pos - PAT_W + 1 > m_last_end);
    endfunction

    function automatic void model_update();
        int p;
        p = m_phase;
        if (p == 0) begin
            if (cfg_we) begin
                m_pat = cfg_pat; m_ovl = cfg_overlap;
                model_clear();
            end
            if (in_valid) begin
                m_word = in_data; m_cnt = 0; m_phase = 1;
            end
        end else if (p <= DATA_W) begin
            if (e_match) begin
                if (m_cnt < CMAX) m_cnt++;
                m_last_end = m_pos;
            end
            m_win.push_back(model_bit());
            if (m_win.size() > PAT_W - 1) void'(m_win.pop_front());
            m_pos++;
            m_phase++;
            if (m_phase == DATA_W + 1) m_match_cnt = m_cnt;
        end else begin
            m_phase = 0;
        end
    endfunction

    task automatic step();
        bit ev;
        @(negedge clk);
        e_match = model_match();
        ev = (m_phase >= 1 && m_phase <= DATA_W);
        chk("in_ready", in_ready, m_phase == 0);
        chk("bit_vld", bit_vld, ev);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_phase == DATA_W + 1);
        chk("match", match, e_match);
        chk("match_cnt", match_cnt, m_match_cnt);
        if (ev) chk("bit_out", bit_out, model_bit());
        s_done = done; s_match = match; s_cnt = match_cnt; s_vld = bit_vld; s_bit = bit_out;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        cfg_we = 1'b0; in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_bit_vld", bit_vld, 0);
        chk("rst_match", match, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_match_cnt", match_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit cfg_now, input logic [PAT_W-1:0] p,
                             input bit ov, input int mid_cfg, output int cnt, output int first_m);
        int lat;
        cfg_we = cfg_now; cfg_pat = p; cfg_overlap = ov;
        in_valid = 1'b1; in_data = w;
        step();
        in_valid = 1'b0; cnt = -1; first_m = -1; lat = -1;
        for (int k = 1; k <= DATA_W + 10; k++) begin
            cfg_we = (k == mid_cfg);
            if (k == mid_cfg) begin cfg_pat = ~p; cfg_overlap = ~ov; end
            in_data = 16'($urandom);
            step();
            if (s_match && first_m < 0) first_m = k;
            if (s_done) begin cnt = s_cnt; lat = k; break; end
        end
        cfg_we = 1'b0;
        chk("done_latency", lat, DATA_W + 1);
    endtask

    typedef struct {
        bit                rst_b;
        int                cfg;      // 0 none, 1 separate idle cycle, 2 same cycle as accept
        logic [PAT_W-1:0]  pat;
        bit                ovl;
        logic [DATA_W-1:0] word;
        int                exp_cnt;
        int                exp_first;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int cnt, fm;
        logic [DATA_W-1:0] acc;
        rst = 1'b1; cfg_we = 1'b0; cfg_pat = '0; cfg_overlap = 1'b0; in_valid = 1'b0; in_data = '0;

        tbl[0] = '{1, 0, 5'b10111, 1, 16'hB800, 1, 5};
        tbl[1] = '{1, 0, 5'b10111, 1, 16'hBB80, 2, 5};
        tbl[2] = '{1, 1, 5'b10111, 0, 16'hBB80, 1, 5};
        tbl[3] = '{1, 0, 5'b10111, 1, 16'h0005, 0, -1};
        tbl[4] = '{0, 0, 5'b10111, 1, 16'hC000, 1, 2};
        tbl[5] = '{0, 2, 5'b11111, 1, 16'hFFFF, 12, 5};
        tbl[6] = '{0, 1, 5'b11111, 0, 16'hFFFF, 3, 5};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rst_b) do_reset();
            if (tbl[i].cfg == 1) begin
                cfg_we = 1'b1; cfg_pat = tbl[i].pat; cfg_overlap = tbl[i].ovl;
                step();
                cfg_we = 1'b0;
            end
            send_word(tbl[i].word, tbl[i].cfg == 2, tbl[i].pat, tbl[i].ovl, 0, cnt, fm);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_first_match", i), fm, tbl[i].exp_first);
            chk($sformatf("tbl%0d_ready_after", i), in_ready, 1);
        end

        // Configuration writes during SHIFT must be ignored.
        cfg_we = 1'b1; cfg_pat = 5'b11111; cfg_overlap = 1'b1;
        step();
        cfg_we = 1'b0;
        send_word(16'hFFFF, 1'b0, 5'b11111, 1'b1, 3, cnt, fm);
        chk("mid_cfg_cnt", cnt, 12);
        send_word(16'hFFFF, 1'b0, 5'b11111, 1'b1, 8, cnt, fm);
        chk("mid_cfg_history_kept", cnt, 16);

        // in_valid held with changing data: only the first latched word is serialised.
        in_valid = 1'b1; in_data = 16'h5A3C;
        step();
        acc = '0;
        for (int k = 1; k <= DATA_W + 1; k++) begin
            in_data = 16'($urandom);
            step();
            if (s_vld) acc = {acc[DATA_W-2:0], s_bit};
        end
        chk("held_valid_word", acc, 16'h5A3C);
        in_valid = 1'b0;
        for (int k = 0; k < DATA_W + 4 && m_phase != 0; k++) step();
        chk("held_valid_drain", in_ready, 1);

        // Reset on the 7th bit: abandon the word and restore the default configuration.
        cfg_we = 1'b1; cfg_pat = 5'b11111; cfg_overlap = 1'b0;
        step();
        cfg_we = 1'b0;
        in_valid = 1'b1; in_data = 16'hB800;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        do_reset();
        send_word(16'hB800, 1'b0, 5'b10111, 1'b1, 0, cnt, fm);
        chk("post_rst_cnt", cnt, 1);
        chk("post_rst_first_match", fm, 5);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'hBDDD;
            cfg_we      = ($urandom_range(0, 15) == 0);
            cfg_pat     = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'b11101;
            cfg_overlap = 1'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
